// File: rtl/param_priority_encoder_if.sv
// Request/result bundle for param_priority_encoder: request vector and mode in,
// registered index/one-hot grant out with a valid/ready handshake.
interface param_priority_encoder_if #(
  parameter int WIDTH = 8
);
  localparam int OUT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in;
  logic             rr_en;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic [WIDTH-1:0] grant;
  logic             out_valid;

  modport master (
    output in, rr_en, out_ready,
    input  out, grant, out_valid
  );

  modport slave (
    input  in, rr_en, out_ready,
    output out, grant, out_valid
  );
endinterface

// File: rtl/param_priority_encoder.sv
// Registered WIDTH-input priority encoder with a run-time choice of fixed MSB-first
// or round-robin priority; the result is held until the consumer accepts it.
module param_priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  param_priority_encoder_if.slave  bus
);
  localparam int OUT_W = $clog2(WIDTH);

  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;

  logic             load;
  logic             any_req;
  logic [WIDTH-1:0] above;
  logic [WIDTH-1:0] fixed_oh;
  logic [WIDTH-1:0] rr_mask;
  logic [WIDTH-1:0] hi_req;
  logic [WIDTH-1:0] rr_src;
  logic [WIDTH-1:0] rr_oh;
  logic [WIDTH-1:0] win_oh;
  logic [OUT_W-1:0] win_idx;
  logic [OUT_W-1:0] ptr_next;

  assign any_req = |bus.in;

  // above[i] is set when any request with a higher index is present.
  assign above[WIDTH-1] = 1'b0;
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_above
    assign above[gi] = above[gi+1] | bus.in[gi+1];
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
    assign fixed_oh[gi] = bus.in[gi] & ~above[gi];
    assign rr_mask[gi]  = (OUT_W'(gi) >= ptr_q);
  end

  // Round-robin: lowest request at or above ptr, else lowest overall (the wrap).
  assign hi_req = bus.in & rr_mask;
  assign rr_src = (|hi_req) ? hi_req : bus.in;
  assign rr_oh  = rr_src & (~rr_src + WIDTH'(1));
  assign win_oh = bus.rr_en ? rr_oh : fixed_oh;

  for (genvar gb = 0; gb < OUT_W; gb++) begin : g_enc
    logic [WIDTH-1:0] bit_mask;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign bit_mask[gi] = ((gi >> gb) % 2) == 1;
    end
    assign win_idx[gb] = |(win_oh & bit_mask);
  end

  assign ptr_next = (win_idx == OUT_W'(WIDTH - 1)) ? '0 : win_idx + OUT_W'(1);
  assign load     = !valid_q || bus.out_ready;

  always_comb begin
    out_d   = out_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = any_req;
      if (any_req) begin
        out_d   = win_idx;
        grant_d = win_oh;
        if (bus.rr_en) begin
          ptr_d = ptr_next;
        end
      end else begin
        out_d   = '0;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      out_q   <= out_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_param_priority_encoder.sv
// Directed-vector bench for param_priority_encoder: an 8-wide instance for the main
// scenarios and a 5-wide instance for the non-power-of-2 pointer wrap.
module tb_param_priority_encoder;
  logic clk = 1'b0;
  logic rst;
  logic rst5;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  param_priority_encoder_if #(.WIDTH(8)) bus8();
  param_priority_encoder_if #(.WIDTH(5)) bus5();

  param_priority_encoder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst),  .bus(bus8.slave));
  param_priority_encoder #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5.slave));

  task automatic test_reset();
    rst = 1'b1; rst5 = 1'b1;
    bus8.in = 8'hFF; bus8.rr_en = 1'b0; bus8.out_ready = 1'b1;
    bus5.in = 5'h00; bus5.rr_en = 1'b0; bus5.out_ready = 1'b1;
    #2 rst = 1'b0; rst5 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus8.out_valid, bus8.out, bus8.grant} !== 12'h000) begin
        $display("FAIL reset_hold[%0d]: valid=%b out=%0d grant=%h, required valid=0 out=0 grant=00",
                 k, bus8.out_valid, bus8.out, bus8.grant);
        miscompares++;
      end else $display("reset_hold[%0d] valid=0 out=0 grant=00", k);
    end
    vectors++;
    if (dut8.ptr_q !== 3'd0) begin
      $display("FAIL reset_ptr: ptr=%0d, required 0", dut8.ptr_q);
      miscompares++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus8.out_valid, bus8.out, bus8.grant} !== {1'b1, 3'd7, 8'h80}) begin
      $display("FAIL reset_release: valid=%b out=%0d grant=%h, required valid=1 out=7 grant=80",
               bus8.out_valid, bus8.out, bus8.grant);
      miscompares++;
    end else $display("reset_release in=ff out=7 grant=80");
  endtask

  task automatic test_fixed();
    logic [7:0]  vin [4] = '{8'h40, 8'h04, 8'h29, 8'h00};
    logic [11:0] exp [4] = '{{1'b1, 3'd6, 8'h40}, {1'b1, 3'd2, 8'h04},
                             {1'b1, 3'd5, 8'h20}, {1'b0, 3'd0, 8'h00}};
    bus8.rr_en = 1'b0; bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus8.in = vin[k];
      @(posedge clk); #1;
      vectors++;
      if ({bus8.out_valid, bus8.out, bus8.grant} !== exp[k]) begin
        $display("FAIL fixed[%0d]: in=%h got {valid,out,grant}=%h, required %h",
                 k, vin[k], {bus8.out_valid, bus8.out, bus8.grant}, exp[k]);
        miscompares++;
      end else $display("fixed[%0d] in=%h out=%0d grant=%h valid=%b",
                        k, vin[k], bus8.out, bus8.grant, bus8.out_valid);
    end
  endtask

  task automatic test_rr_walk();
    logic [2:0] ei;
    logic [2:0] ep;
    bus8.rr_en = 1'b1; bus8.out_ready = 1'b1; bus8.in = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      ei = 3'(k % 8);
      ep = 3'((k + 1) % 8);
      @(posedge clk); #1;
      vectors++;
      if ({bus8.out_valid, bus8.out, bus8.grant} !== {1'b1, ei, 8'(8'd1 << ei)}) begin
        $display("FAIL rr_walk[%0d]: valid=%b out=%0d grant=%h, required out=%0d grant=%h",
                 k, bus8.out_valid, bus8.out, bus8.grant, ei, 8'(8'd1 << ei));
        miscompares++;
      end else $display("rr_walk[%0d] out=%0d grant=%h", k, bus8.out, bus8.grant);
      vectors++;
      if (dut8.ptr_q !== ep) begin
        $display("FAIL rr_walk_ptr[%0d]: ptr=%0d, required %0d", k, dut8.ptr_q, ep);
        miscompares++;
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp [3] = '{3'd7, 3'd0, 3'd7};
    bus8.rr_en = 1'b1; bus8.out_ready = 1'b1; bus8.in = 8'h81;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus8.out_valid !== 1'b1 || bus8.out !== exp[k]) begin
        $display("FAIL rr_wrap[%0d]: valid=%b out=%0d, required valid=1 out=%0d",
                 k, bus8.out_valid, bus8.out, exp[k]);
        miscompares++;
      end else $display("rr_wrap[%0d] in=81 out=%0d grant=%h", k, bus8.out, bus8.grant);
    end
  endtask

  task automatic test_backpressure();
    bus8.rr_en = 1'b0; bus8.out_ready = 1'b1; bus8.in = 8'h04;
    @(posedge clk); #1;
    vectors++;
    if ({bus8.out_valid, bus8.out} !== {1'b1, 3'd2}) begin
      $display("FAIL bp_first: valid=%b out=%0d, required valid=1 out=2", bus8.out_valid, bus8.out);
      miscompares++;
    end else $display("bp_first in=04 out=2");
    bus8.out_ready = 1'b0; bus8.in = 8'h80;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus8.out_valid, bus8.out, bus8.grant, dut8.ptr_q} !== {1'b1, 3'd2, 8'h04, 3'd0}) begin
        $display("FAIL bp_hold[%0d]: valid=%b out=%0d grant=%h ptr=%0d, required valid=1 out=2 grant=04 ptr=0",
                 k, bus8.out_valid, bus8.out, bus8.grant, dut8.ptr_q);
        miscompares++;
      end else $display("bp_hold[%0d] in=80 ready=0 out=2 held", k);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus8.out_valid, bus8.out, bus8.grant} !== {1'b1, 3'd7, 8'h80}) begin
      $display("FAIL bp_release: valid=%b out=%0d grant=%h, required valid=1 out=7 grant=80",
               bus8.out_valid, bus8.out, bus8.grant);
      miscompares++;
    end else $display("bp_release in=80 out=7");
  endtask

  task automatic test_mode_switch();
    logic [7:0] vin [4] = '{8'h04, 8'h01, 8'h0A, 8'h00};
    logic       vrr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] eout [4] = '{{1'b1, 3'd2}, {1'b1, 3'd0}, {1'b1, 3'd3}, {1'b0, 3'd0}};
    logic [2:0] eptr [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus8.in = vin[k]; bus8.rr_en = vrr[k];
      @(posedge clk); #1;
      vectors++;
      if ({bus8.out_valid, bus8.out, dut8.ptr_q} !== {eout[k], eptr[k]}) begin
        $display("FAIL mode_switch[%0d]: valid=%b out=%0d ptr=%0d, required valid=%b out=%0d ptr=%0d",
                 k, bus8.out_valid, bus8.out, dut8.ptr_q, eout[k][3], eout[k][2:0], eptr[k]);
        miscompares++;
      end else $display("mode_switch[%0d] rr=%b in=%h out=%0d ptr=%0d",
                        k, vrr[k], vin[k], bus8.out, dut8.ptr_q);
    end
  endtask

  task automatic test_width5();
    logic [2:0] eidx [6] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd4, 3'd0};
    logic [2:0] eptr [6] = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 3'd1};
    bus5.in = 5'b1_0001; bus5.rr_en = 1'b1; bus5.out_ready = 1'b1;
    rst5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        rst5 = 1'b0; #1;
        vectors++;
        if ({bus5.out_valid, bus5.grant, dut5.ptr_q} !== {1'b0, 5'h00, 3'd0}) begin
          $display("FAIL w5_async_reset: valid=%b grant=%h ptr=%0d, required valid=0 grant=00 ptr=0",
                   bus5.out_valid, bus5.grant, dut5.ptr_q);
          miscompares++;
        end else $display("w5_async_reset valid=0 grant=00");
        rst5 = 1'b1;
      end
      @(posedge clk); #1;
      vectors++;
      if ({bus5.out_valid, bus5.out, bus5.grant, dut5.ptr_q} !==
          {1'b1, eidx[k], 5'(5'd1 << eidx[k]), eptr[k]}) begin
        $display("FAIL w5_rr[%0d]: valid=%b out=%0d grant=%h ptr=%0d, required out=%0d grant=%h ptr=%0d",
                 k, bus5.out_valid, bus5.out, bus5.grant, dut5.ptr_q,
                 eidx[k], 5'(5'd1 << eidx[k]), eptr[k]);
        miscompares++;
      end else $display("w5_rr[%0d] in=11 out=%0d grant=%h ptr=%0d",
                        k, bus5.out, bus5.grant, dut5.ptr_q);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_walk();
    test_rr_wrap();
    test_backpressure();
    test_mode_switch();
    test_width5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
